// File: rtl/spu_mailbox_pkg.sv
// Shared types and constants for the SPU mailbox responder.
package spu_mailbox_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_e;

    // Control PIO bit positions
    localparam int unsigned CTRL_REQ     = 0;
    localparam int unsigned CTRL_CLR_ERR = 1;

    // Status PIO bit positions
    localparam int unsigned STAT_ACK     = 0;
    localparam int unsigned STAT_BUSY    = 1;
    localparam int unsigned STAT_ERR     = 2;
    localparam int unsigned STAT_LTO     = 3;
    localparam int unsigned STAT_SEQ_LSB = 8;
    localparam int unsigned STAT_SEQ_W   = 8;
    localparam int unsigned STATUS_W     = 32;

    // Result published when the SPU never answers (IEEE-754 quiet NaN)
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Assemble the software-visible status word; unused bits read as zero
    function automatic logic [STATUS_W-1:0] pack_status(
        input logic                  ack,
        input logic                  busy,
        input logic                  err,
        input logic                  lto,
        input logic [STAT_SEQ_W-1:0] seq
    );
        logic [STATUS_W-1:0] s;
        s                                = '0;
        s[STAT_ACK]                      = ack;
        s[STAT_BUSY]                     = busy;
        s[STAT_ERR]                      = err;
        s[STAT_LTO]                      = lto;
        s[STAT_SEQ_LSB +: STAT_SEQ_W]    = seq;
        return s;
    endfunction

endpackage

// File: rtl/mbox_timeout_ctr.sv
// Cycle counter bounding how long the responder waits for spu_done.
module mbox_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; otherwise count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Final allowed wait cycle reached while counting
    assign expired_c_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spu_mailbox_responder.sv
// Four-phase req/ack responder between the SoC PIOs and the SPU datapath.
module spu_mailbox_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned SEQ_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ctrl_in,
    input  logic [DATA_W-1:0] operand_in,
    output logic [31:0]       status_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] spu_x,
    output logic              spu_start,
    input  logic              spu_done,
    input  logic [DATA_W-1:0] spu_y
);

    import spu_mailbox_pkg::*;

    state_e state_q;
    state_e state_d;

    logic              req_q;
    logic              clr_q;

    logic [DATA_W-1:0] spu_x_q;
    logic [DATA_W-1:0] spu_x_d;
    logic              spu_start_q;
    logic              spu_start_d;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_d;
    logic              ack_q;
    logic              ack_d;
    logic              busy_q;
    logic              busy_d;
    logic              err_q;
    logic              err_d;
    logic              lto_q;
    logic              lto_d;
    logic [SEQ_W-1:0]  seq_q;
    logic [SEQ_W-1:0]  seq_d;

    logic              tmo_clear;
    logic              tmo_en;
    logic              tmo_expired;
    logic              done_evt;
    logic              tmo_evt;

    // Only req and clr_err are meaningful in the control word
    logic              unused_ctrl;
    assign unused_ctrl = ^ctrl_in[31:2];

    // Wait-cycle counter: zeroed at launch, runs only while waiting
    assign tmo_clear = (state_q == LAUNCH);
    assign tmo_en    = (state_q == WAIT);

    mbox_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (tmo_clear),
        .enable_i    (tmo_en),
        .expired_c_o (tmo_expired)
    );

    // Completion wins over a coincident timeout
    assign done_evt = (state_q == WAIT) && spu_done;
    assign tmo_evt  = (state_q == WAIT) && !spu_done && tmo_expired;

    // Synchronise the software control bits once
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            req_q <= ctrl_in[CTRL_REQ];
            clr_q <= ctrl_in[CTRL_CLR_ERR];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_q)                   state_d = LAUNCH;
            LAUNCH:                               state_d = WAIT;
            WAIT:    if (spu_done || tmo_expired) state_d = ACK;
            ACK:     if (!req_q)                  state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs
    always_comb begin
        spu_x_d     = spu_x_q;
        result_d    = result_q;
        err_d       = err_q;
        lto_d       = lto_q;
        seq_d       = seq_q;
        spu_start_d = (state_d == LAUNCH);
        busy_d      = (state_d == LAUNCH) || (state_d == WAIT);
        ack_d       = (state_d == ACK);

        // Operand is frozen at request time and held through the operation
        if ((state_q == IDLE) && req_q) begin
            spu_x_d = operand_in;
        end

        if (done_evt) begin
            result_d = spu_y;
            lto_d    = 1'b0;
        end

        // Clear first so a coincident timeout still leaves err set
        if (clr_q) begin
            err_d = 1'b0;
        end

        if (tmo_evt) begin
            result_d = DATA_W'(QNAN);
            err_d    = 1'b1;
            lto_d    = 1'b1;
        end

        // Count each completed transaction on ACK entry
        if ((state_d == ACK) && (state_q != ACK)) begin
            seq_d = seq_q + SEQ_W'(1);
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            spu_x_q     <= '0;
            spu_start_q <= 1'b0;
            result_q    <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            lto_q       <= 1'b0;
            seq_q       <= '0;
        end else begin
            spu_x_q     <= spu_x_d;
            spu_start_q <= spu_start_d;
            result_q    <= result_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            lto_q       <= lto_d;
            seq_q       <= seq_d;
        end
    end

    assign spu_x      = spu_x_q;
    assign spu_start  = spu_start_q;
    assign result_out = result_q;
    assign status_out = pack_status(ack_q, busy_q, err_q, lto_q, STAT_SEQ_W'(seq_q));

endmodule

// File: tb/tb_spu_mailbox_responder.sv
// Directed, table-driven bench for spu_mailbox_responder (TIMEOUT_CYC = 16).
module tb_spu_mailbox_responder;

    localparam int unsigned DW   = 32;
    localparam int unsigned TMO  = 16;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic          clk;
    logic          reset;
    logic [31:0]   ctrl_in;
    logic [DW-1:0] operand_in;
    logic [31:0]   status_out;
    logic [DW-1:0] result_out;
    logic [DW-1:0] spu_x;
    logic          spu_start;
    logic          spu_done;
    logic [DW-1:0] spu_y;

    spu_mailbox_responder #(
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO),
        .SEQ_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_in    (ctrl_in),
        .operand_in (operand_in),
        .status_out (status_out),
        .result_out (result_out),
        .spu_x      (spu_x),
        .spu_start  (spu_start),
        .spu_done   (spu_done),
        .spu_y      (spu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: tmo=1 means the SPU never answers; otherwise done
    // is driven lat cycles after the spu_start cycle (lat 16 = timeout cycle)
    typedef struct {
        logic [31:0] op;
        int          lat;
        logic [31:0] y;
        bit          tmo;
        bit          post_clr;
        logic [31:0] exp_res;
        bit          exp_err;
        bit          exp_lto;
    } vec_t;

    int         checks;
    int         errors;
    int         start_cnt;
    logic [7:0] exp_seq;
    vec_t       vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (spu_start === 1'b1) start_cnt++;
    endtask

    function automatic logic [31:0] exp_status(input bit ack, input bit busy,
                                               input bit err, input bit lto);
        return {16'h0, exp_seq, 4'h0, lto, err, busy, ack};
    endfunction

    task automatic run_txn(input vec_t v);
        int n;
        int s0;
        int wait_cyc;
        s0         = start_cnt;
        operand_in = v.op;
        ctrl_in    = 32'h1;
        n          = 0;
        while (spu_start !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("start_latency", 32'(n), 32'd2);
        if (spu_start !== 1'b1) begin
            ctrl_in = 32'h0;
            return;
        end
        // Now in the launch cycle S
        wait_cyc = v.tmo ? int'(TMO) : v.lat;
        for (int k = 1; k <= wait_cyc; k++) begin
            tick();
            if (k == 1) operand_in = ~v.op;
        end
        if (v.tmo) begin
            chk("ack_before_timeout", 32'(status_out[1:0]), 32'b10);
            tick();
        end else begin
            chk("busy_in_wait", 32'(status_out[1:0]), 32'b10);
            spu_done = 1'b1;
            spu_y    = v.y;
            tick();
            spu_done = 1'b0;
            spu_y    = 32'hFFFF_FFFF;
        end
        exp_seq = exp_seq + 8'd1;
        chk("ack_status", status_out, exp_status(1'b1, 1'b0, v.exp_err, v.exp_lto));
        chk("result", result_out, v.exp_res);
        chk("spu_x_held", spu_x, v.op);
        chk("one_start", 32'(start_cnt - s0), 32'd1);
        ctrl_in = 32'h0;
        tick();
        chk("ack_hold", 32'(status_out[0]), 32'd1);
        tick();
        chk("ack_drop", status_out, exp_status(1'b0, 1'b0, v.exp_err, v.exp_lto));
        if (v.post_clr) begin
            ctrl_in = 32'h2;
            tick();
            tick();
            ctrl_in = 32'h0;
            chk("clr_err", status_out, exp_status(1'b0, 1'b0, 1'b0, v.exp_lto));
        end
    endtask

    initial begin
        int   s0;
        vec_t bv;
        checks     = 0;
        errors     = 0;
        start_cnt  = 0;
        exp_seq    = 8'd0;
        reset      = 1'b1;
        ctrl_in    = 32'h0;
        operand_in = '0;
        spu_done   = 1'b0;
        spu_y      = '0;

        vecs[0] = '{op: 32'h4000_0000, lat: 10, y: 32'h3F80_0000, tmo: 1'b0, post_clr: 1'b0,
                    exp_res: 32'h3F80_0000, exp_err: 1'b0, exp_lto: 1'b0};
        vecs[1] = '{op: 32'hC0A0_0000, lat: 1,  y: 32'h4120_0000, tmo: 1'b0, post_clr: 1'b0,
                    exp_res: 32'h4120_0000, exp_err: 1'b0, exp_lto: 1'b0};
        vecs[2] = '{op: 32'h1111_1111, lat: 0,  y: 32'h0,         tmo: 1'b1, post_clr: 1'b1,
                    exp_res: QNAN,          exp_err: 1'b1, exp_lto: 1'b1};
        vecs[3] = '{op: 32'h2222_2222, lat: 16, y: 32'h1234_5678, tmo: 1'b0, post_clr: 1'b0,
                    exp_res: 32'h1234_5678, exp_err: 1'b0, exp_lto: 1'b0};
        vecs[4] = '{op: 32'h3333_3333, lat: 15, y: 32'h0BAD_F00D, tmo: 1'b0, post_clr: 1'b0,
                    exp_res: 32'h0BAD_F00D, exp_err: 1'b0, exp_lto: 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_status", status_out, 32'h0);
        chk("rst_result", result_out, 32'h0);
        chk("rst_spu_x", spu_x, 32'h0);
        chk("rst_start", 32'(spu_start), 32'd0);
        reset     = 1'b0;
        start_cnt = 0;
        repeat (5) tick();
        chk("idle_status", status_out, 32'h0);
        chk("idle_result", result_out, 32'h0);
        chk("idle_no_start", 32'(start_cnt), 32'd0);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Reset while waiting, then a stray done
        operand_in = 32'hABCD_0123;
        ctrl_in    = 32'h1;
        repeat (2) tick();
        chk("rw_start", 32'(spu_start), 32'd1);
        repeat (3) tick();
        reset   = 1'b1;
        ctrl_in = 32'h0;
        tick();
        chk("rw_status", status_out, 32'h0);
        chk("rw_result", result_out, 32'h0);
        chk("rw_spu_x", spu_x, 32'h0);
        chk("rw_start_low", 32'(spu_start), 32'd0);
        reset    = 1'b0;
        s0       = start_cnt;
        spu_done = 1'b1;
        spu_y    = 32'hDEAD_BEEF;
        tick();
        spu_done = 1'b0;
        repeat (4) tick();
        chk("late_done_status", status_out, 32'h0);
        chk("late_done_result", result_out, 32'h0);
        chk("late_done_no_start", 32'(start_cnt - s0), 32'd0);
        exp_seq = 8'd0;

        // 256 back-to-back transactions wrap the sequence count
        for (int i = 0; i < 256; i++) begin
            bv.op       = 32'(i) * 32'h0101_0101 + 32'h0F00_0000;
            bv.lat      = 1 + (i % 16);
            bv.y        = 32'hA500_0000 | 32'(i);
            bv.tmo      = 1'b0;
            bv.post_clr = 1'b0;
            bv.exp_res  = 32'hA500_0000 | 32'(i);
            bv.exp_err  = 1'b0;
            bv.exp_lto  = 1'b0;
            run_txn(bv);
        end
        chk("seq_wrap", 32'(status_out[15:8]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
